// File: rtl/reg_buffer_ctrl.sv
// Purpose : valid-bit tracker, occupancy counter and IDLE/RUN/FLUSH sequencer for a DELAY-stage register-buffer array.
// Latency : a beat accepted in cycle t presents m_valid in cycle t+DELAY when the output is not stalled.
// Backpr. : a stall at the output (m_valid & ~m_ready) freezes the whole array and drops s_ready; no beat is lost.
//
// Ports:
//   clk        - single clock, rising edge
//   rstn       - synchronous reset, active HIGH despite the name (1 = reset)
//   start      - one-cycle request to begin accepting beats (IDLE -> RUN)
//   flush      - one-cycle request to stop accepting and drain (RUN -> FLUSH)
//   s_valid    - upstream beat valid
//   s_ready    - upstream beat accepted this cycle (never depends on s_valid)
//   m_valid    - array output stage holds a valid beat
//   m_ready    - downstream accepts the output beat
//   buf_en     - shared shift enable for the array stages
//   occupancy  - number of valid beats currently in the array
//   busy       - state is not IDLE
//   flush_done - one-cycle pulse when a drain has emptied the array
module reg_buffer_ctrl #(
    parameter int DELAY = 4,   // stage count, >= 2
    parameter int CNT_W = 4    // occupancy width, 2**CNT_W > DELAY
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             buf_en,
    output logic [CNT_W-1:0] occupancy,
    output logic             busy,
    output logic             flush_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           state_q;
    state_t           state_d;
    logic [DELAY-1:0] v_q;
    logic [CNT_W-1:0] occ_q;

    logic             in_rst;
    logic             out_vld;
    logic             advance;
    logic             s_fire;
    logic             m_fire;
    logic             drained;

    // Outputs are forced quiet for the whole time reset is held, so nothing
    // downstream sees stale state in the reset cycle itself.
    assign in_rst  = rstn;
    assign out_vld = v_q[DELAY-1] & ~in_rst;

    // The array shifts as one unit: it may move whenever the output stage is
    // empty or being taken.
    assign advance = ~out_vld | m_ready;
    assign s_ready = advance & (state_q == RUN) & ~in_rst;
    assign s_fire  = s_valid & s_ready;
    assign m_fire  = out_vld & m_ready;

    // Only clock the datapath when something is actually in it or entering.
    assign buf_en  = advance & (s_fire | (|v_q)) & ~in_rst;

    assign drained    = (occ_q == '0);
    assign m_valid    = out_vld;
    assign occupancy  = in_rst ? '0 : occ_q;
    assign busy       = (state_q != IDLE) & ~in_rst;
    assign flush_done = (state_q == FLUSH) & drained & ~in_rst;

    // State register, valid vector and occupancy counter.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= IDLE;
            v_q     <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            if (advance) begin
                v_q <= {v_q[DELAY-2:0], s_fire};
            end
            // Simultaneous enter and leave cancel; counter tracks popcount(v).
            if (s_fire && !m_fire) begin
                occ_q <= occ_q + CNT_ONE;
            end else if (m_fire && !s_fire) begin
                occ_q <= occ_q - CNT_ONE;
            end
        end
    end

    // Next-state logic. Start wins over flush in IDLE simply because flush is
    // not looked at there; start is not looked at in RUN or FLUSH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (drained) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_buffer_ctrl.sv
// Purpose : self-checking bench for reg_buffer_ctrl against a beat-level reference model.
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_reg_buffer_ctrl;

    localparam int DELAY = 4;
    localparam int CNT_W = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLUSH = 2;

    logic             clk;
    logic             rstn;
    logic             start;
    logic             flush;
    logic             s_valid;
    logic             s_ready;
    logic             m_valid;
    logic             m_ready;
    logic             buf_en;
    logic [CNT_W-1:0] occupancy;
    logic             busy;
    logic             flush_done;

    reg_buffer_ctrl #(.DELAY(DELAY), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .flush      (flush),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .buf_en     (buf_en),
        .occupancy  (occupancy),
        .busy       (busy),
        .flush_done (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Reference model: array slots hold beat ids (-1 = bubble); the
    // scoreboard queue holds accepted-but-not-delivered ids in order.
    int mstate;
    int slot [DELAY];
    int sb [$];
    int next_id;

    // DUT values sampled mid-cycle by the last step.
    logic             o_mv;
    logic             o_sr;
    logic             o_be;
    logic             o_busy;
    logic             o_fd;
    logic [CNT_W-1:0] o_occ;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare at the falling edge, advance model.
    task automatic step(input bit st, input bit fl, input bit sv, input bit mr, input bit rs);
        bit e_mv, e_adv, e_sr, e_be, e_fd, e_busy, sf, mf, any;
        int e_occ;
        int out_id;
        start   = st;
        flush   = fl;
        s_valid = sv;
        m_ready = mr;
        rstn    = rs;
        #4;
        any = 0;
        for (int i = 0; i < DELAY; i++) if (slot[i] >= 0) any = 1;
        if (rs) begin
            e_mv = 0; e_adv = 1; e_sr = 0; sf = 0; mf = 0;
            e_be = 0; e_occ = 0; e_fd = 0; e_busy = 0;
        end else begin
            e_mv   = (slot[DELAY-1] >= 0);
            e_adv  = !e_mv || mr;
            e_sr   = e_adv && (mstate == M_RUN);
            sf     = sv && e_sr;
            mf     = e_mv && mr;
            e_be   = e_adv && (sf || any);
            e_occ  = sb.size();
            e_fd   = (mstate == M_FLUSH) && (sb.size() == 0);
            e_busy = (mstate != M_IDLE);
        end
        o_mv = m_valid; o_sr = s_ready; o_be = buf_en;
        o_busy = busy; o_fd = flush_done; o_occ = occupancy;
        chk("m_valid", int'(o_mv), int'(e_mv));
        chk("s_ready", int'(o_sr), int'(e_sr));
        chk("buf_en", int'(o_be), int'(e_be));
        chk("occupancy", int'(o_occ), e_occ);
        chk("busy", int'(o_busy), int'(e_busy));
        chk("flush_done", int'(o_fd), int'(e_fd));
        if (rs) begin
            mstate = M_IDLE;
            for (int i = 0; i < DELAY; i++) slot[i] = -1;
            sb.delete();
        end else begin
            case (mstate)
                M_IDLE:  if (st) mstate = M_RUN;
                M_RUN:   if (fl) mstate = M_FLUSH;
                default: if (sb.size() == 0) mstate = M_IDLE;
            endcase
            if (mf) out_id = sb.pop_front();
            if (sf) sb.push_back(next_id);
            if (e_adv) begin
                for (int i = DELAY - 1; i > 0; i--) slot[i] = slot[i-1];
                slot[0] = sf ? next_id : -1;
            end
            if (sf) next_id++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_sf, first_mv, peak, mf_cnt, fd_cnt;
        bit be_all, stall_ok, sr_any;
        total = 0;
        bad = 0;
        next_id = 0;
        mstate = M_IDLE;
        for (int i = 0; i < DELAY; i++) slot[i] = -1;
        start = 0; flush = 0; s_valid = 0; m_ready = 0; rstn = 1;
        @(posedge clk);
        #1;

        // Reset held for a few cycles: all outputs quiet.
        repeat (3) step(0, 0, 0, 0, 1);

        // Streaming: 8 beats with m_ready held high.
        step(1, 0, 0, 1, 0);
        first_sf = -1; first_mv = -1; peak = 0; be_all = 1; mf_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 1, 0);
            if (o_sr && first_sf < 0) first_sf = i;
            if (o_mv && first_mv < 0) first_mv = i;
            if (int'(o_occ) > peak) peak = int'(o_occ);
            if (!o_be) be_all = 0;
            if (o_mv) mf_cnt++;
        end
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 1, 0);
            if (o_occ == 0) break;
            if (o_mv) mf_cnt++;
        end
        chk("stream_latency", first_mv - first_sf, DELAY);
        chk("stream_peak_occ", peak, 4);
        chk("stream_buf_en_all", int'(be_all), 1);
        chk("stream_m_fires", mf_cnt, 8);

        // Back-pressure: fill to 4, stall 5 cycles, release.
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0, 0);
            if (o_occ == 4) break;
        end
        chk("bp_fill_occ", int'(o_occ), 4);
        stall_ok = 1;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 0);
            if (o_sr || o_be || !o_mv || o_occ != 4) stall_ok = 0;
        end
        chk("bp_stall_frozen", int'(stall_ok), 1);
        step(0, 0, 1, 1, 0);
        chk("bp_release_s_ready", int'(o_sr), 1);
        mf_cnt = int'(o_mv);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 1, 0);
            if (o_occ == 0) break;
            if (o_mv) mf_cnt++;
        end
        chk("bp_delivered", mf_cnt, 5);

        // Flush drain with 3 beats in flight.
        repeat (3) step(0, 0, 1, 1, 0);
        step(0, 1, 0, 1, 0);
        mf_cnt = 0; fd_cnt = 0; sr_any = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 1, 0);
            if (!o_busy) break;
            if (o_sr) sr_any = 1;
            if (o_mv) mf_cnt++;
            if (o_fd) fd_cnt++;
        end
        chk("flush_m_fires", mf_cnt, 3);
        chk("flush_done_pulses", fd_cnt, 1);
        chk("flush_s_ready_low", int'(sr_any), 0);
        chk("flush_back_idle", int'(o_busy), 0);

        // Start together with flush in IDLE goes to RUN.
        step(1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("start_flush_run", int'(o_busy), 1);
        chk("start_flush_no_fd", int'(o_fd), 0);
        // Flush of an empty array completes in the FLUSH entry cycle.
        step(0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("empty_flush_fd", int'(o_fd), 1);
        step(0, 0, 0, 1, 0);
        chk("empty_flush_idle", int'(o_busy), 0);

        // Simultaneous s_fire and m_fire keeps occupancy steady.
        step(1, 0, 0, 1, 0);
        repeat (6) step(0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 0);
            chk("both_fire", int'(o_sr && o_mv), 1);
            chk("both_fire_occ", int'(o_occ), 4);
        end

        // Reset mid-FLUSH with occupancy 2.
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 1, 0);
            if (o_occ == 0) break;
        end
        repeat (2) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("midflush_occ", int'(o_occ), 2);
        chk("midflush_busy", int'(o_busy), 1);
        step(0, 0, 0, 0, 1);
        chk("midflush_rst_no_fd", int'(o_fd), 0);
        // First cycle after reset: start must be honoured.
        step(1, 0, 0, 0, 0);
        chk("post_rst_occ", int'(o_occ), 0);
        chk("post_rst_m_valid", int'(o_mv), 0);
        chk("post_rst_idle", int'(o_busy), 0);
        step(0, 0, 0, 1, 0);
        chk("post_rst_start", int'(o_busy), 1);

        // Randomised traffic with occasional control pulses and resets.
        for (int n = 0; n < 10000; n++) begin
            step($urandom_range(0, 15) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 499) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
